// File: rtl/wordcount_word_unpacker_if.sv
// Handshake bundle between the beat reader, the unpacker and the word consumer.
// slave = the unpacker's view, master = the surrounding controller/bench.
interface wordcount_word_unpacker_if;
  logic         kick;
  logic         busy;
  logic         done;
  logic [31:0]  num_of_words;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_word_valid;
  logic         m_word_ready;
  logic [31:0]  m_word_data;
  logic         m_word_last;

  modport slave (
    input  kick, num_of_words, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_word_ready,
    output busy, done, s_axis_tready, m_word_valid, m_word_data, m_word_last
  );

  modport master (
    output kick, num_of_words, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_word_ready,
    input  busy, done, s_axis_tready, m_word_valid, m_word_data, m_word_last
  );
endinterface

// File: rtl/wordcount_word_unpacker.sv
// Splits 512-bit beats into 32-bit words, MSB lane first, emitting exactly
// num_of_words words per kick and reading only the beats those words need.
module wordcount_word_unpacker (
  input  logic                             clk,
  input  logic                             reset,
  wordcount_word_unpacker_if.slave         bus,
  output logic [1:0]                       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q;
  logic [511:0] buf_q;
  logic [3:0]   idx_q;
  logic [31:0]  rem_q;
  logic         busy_q;
  logic         done_q;
  logic         tready_q;
  logic         valid_q;
  logic         last_q;
  logic [31:0]  data_q;

  logic [3:0]   idx_d;
  logic [31:0]  lane_d;
  logic         unused_tlast;

  // Job length comes only from num_of_words; tlast carries no meaning here.
  assign unused_tlast = bus.s_axis_tlast;

  // Lane i sits at bits [(15-i)*32 +: 32]; (15-i)*32 == {~i, 5'b0}.
  always_comb begin
    idx_d  = idx_q + 4'd1;
    lane_d = buf_q[{~idx_d, 5'd0} +: 32];
  end

  // Both handshakes follow valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; valid and data hold until then.
  // Every output below is a flop, so tready never depends on tvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.kick) begin
            rem_q  <= bus.num_of_words;
            busy_q <= 1'b1;
            if (bus.num_of_words == 32'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tready_q <= 1'b1;
              state_q  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.s_axis_tvalid) begin
            buf_q    <= bus.s_axis_tdata;
            idx_q    <= 4'd0;
            tready_q <= 1'b0;
            valid_q  <= 1'b1;
            data_q   <= bus.s_axis_tdata[511:480];
            last_q   <= (rem_q == 32'd1);
            state_q  <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.m_word_ready) begin
            rem_q <= rem_q - 32'd1;
            idx_q <= idx_d;
            if (rem_q == 32'd1) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (idx_q == 4'd15) begin
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              tready_q <= 1'b1;
              state_q  <= S_LOAD;
            end else begin
              data_q <= lane_d;
              last_q <= (rem_q == 32'd2);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.s_axis_tready = tready_q;
  assign bus.m_word_valid  = valid_q;
  assign bus.m_word_data   = data_q;
  assign bus.m_word_last   = last_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_wordcount_word_unpacker.sv
// Directed bench for wordcount_word_unpacker: fixed 16-lane beat, expected
// word stream queued per job and compared word by word as it is accepted.
module tb_wordcount_word_unpacker;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  wordcount_word_unpacker_if u_if ();

  wordcount_word_unpacker dut (
    .clk         (clk),
    .reset       (rst),
    .bus         (u_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int word_cnt = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int tready_cyc = 0;
  int exp_total = 0;
  int word_base, beat_base, done_base, tready_base;
  logic [32:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] stall_word = '0;
  logic        ready_toggle = 1'b0;
  logic        ready_lvl = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_word(input int l);
    case (l / 4)
      0:       lane_word = (l % 2 == 0) ? 32'h01234567 : 32'h89abcdef;
      1:       lane_word = 32'hdeadbeef;
      2:       lane_word = 32'habadcafe;
      default: lane_word = 32'h11c0ffee;
    endcase
  endfunction

  function automatic logic [511:0] make_beat();
    logic [511:0] b;
    b = '0;
    for (int l = 0; l < 16; l++) b[(15 - l) * 32 +: 32] = lane_word(l);
    return b;
  endfunction

  // ---------------- word-ready driver (sole writer of m_word_ready) ----------------
  initial begin
    u_if.m_word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) u_if.m_word_ready = ~u_if.m_word_ready;
      else              u_if.m_word_ready = ready_lvl;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (u_if.s_axis_tvalid && u_if.s_axis_tready) beat_cnt++;
      if (u_if.s_axis_tready) tready_cyc++;
      if (u_if.done) done_cnt++;
      if (stall_prev)
        check_eq("stall_hold", {u_if.m_word_valid, u_if.m_word_last, u_if.m_word_data},
                 {1'b1, stall_word});
      stall_prev = u_if.m_word_valid && !u_if.m_word_ready;
      stall_word = {u_if.m_word_last, u_if.m_word_data};
      if (u_if.m_word_valid && u_if.m_word_ready) begin
        word_cnt++;
        if (exp_q.size() == 0) check_eq("extra_word", word_cnt - word_base, exp_total);
        else check_eq("word", {u_if.m_word_last, u_if.m_word_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input int n);
    word_base   = word_cnt;
    beat_base   = beat_cnt;
    done_base   = done_cnt;
    tready_base = tready_cyc;
    exp_total   = n;
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), lane_word(k % 16)});
    @(posedge clk);
    #1;
    u_if.kick         = 1'b1;
    u_if.num_of_words = n;
    @(posedge clk);
    #1;
    u_if.kick = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int n, input int beats, input int budget);
    int c;
    c = 0;
    while (done_cnt == done_base && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_done_seen"}, done_cnt - done_base, 1);
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_done_once"}, done_cnt - done_base, 1);
    check_eq({tag, "_busy_after"}, u_if.busy, 0);
    check_eq({tag, "_words"}, word_cnt - word_base, n);
    check_eq({tag, "_beats"}, beat_cnt - beat_base, beats);
    check_eq({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"},   u_if.busy, 0);
    check_eq({tag, "_done"},   u_if.done, 0);
    check_eq({tag, "_tready"}, u_if.s_axis_tready, 0);
    check_eq({tag, "_valid"},  u_if.m_word_valid, 0);
    check_eq({tag, "_last"},   u_if.m_word_last, 0);
    check_eq({tag, "_data"},   u_if.m_word_data, 0);
    check_eq({tag, "_state"},  dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    rst                = 1'b1;
    u_if.kick          = 1'b0;
    u_if.num_of_words  = '0;
    u_if.s_axis_tvalid = 1'b1;
    u_if.s_axis_tdata  = make_beat();
    u_if.s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // N=128: eight full beats, tlast held high to show it is ignored
    u_if.s_axis_tlast = 1'b1;
    start_job(128);
    finish_job("n128", 128, 8, 400);
    u_if.s_axis_tlast = 1'b0;

    // N=20: second beat only partly used
    start_job(20);
    finish_job("n20", 20, 2, 100);

    // N=0: done straight from IDLE, busy for a single cycle
    start_job(0);
    @(negedge clk);
    check_eq("n0_done_pulse", u_if.done, 1);
    check_eq("n0_busy_high", u_if.busy, 1);
    @(negedge clk);
    check_eq("n0_done_low", u_if.done, 0);
    check_eq("n0_busy_low", u_if.busy, 0);
    check_eq("n0_tready_cycles", tready_cyc - tready_base, 0);
    finish_job("n0", 0, 0, 5);

    // N=16 with tvalid held off in LOAD, then ready toggling each cycle
    u_if.s_axis_tvalid = 1'b0;
    start_job(16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("load_tready", u_if.s_axis_tready, 1);
      check_eq("load_no_word", u_if.m_word_valid, 0);
      @(posedge clk);
      #1;
    end
    ready_toggle       = 1'b1;
    u_if.s_axis_tvalid = 1'b1;
    finish_job("n16_stall", 16, 1, 100);
    ready_toggle = 1'b0;
    ready_lvl    = 1'b1;
    repeat (2) @(posedge clk);

    // N=32 with a stray kick mid-job
    start_job(32);
    repeat (8) @(posedge clk);
    #1;
    u_if.kick         = 1'b1;
    u_if.num_of_words = 32'd5;
    @(posedge clk);
    #1;
    u_if.kick = 1'b0;
    finish_job("n32_rekick", 32, 2, 150);

    // Reset after the fifth word of a long job, then a fresh short job
    start_job(128);
    c = 0;
    while ((word_cnt - word_base) < 5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_eq("pre_reset_words", word_cnt - word_base, 5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midjob_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midjob_no_done", done_cnt - done_base, 0);
    start_job(4);
    finish_job("after_reset_n4", 4, 1, 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
